// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: RV64 MEM stage. Issues the EX load/store on a
// valid/ready data-memory port, aligns/extends load data, builds store
// strobes, stalls EX while an access is outstanding, registers to WB.
// Ports: clk/reset (async, active-low), flush, stall (downstream hold),
// *_EX inputs from EX, req_* / resp_* memory port, stall_req to EX,
// *_MEM registered results toward WB.
module pipeline_mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic [XLEN-1:0]   alu_result_EX,
    input  logic [XLEN-1:0]   reg_data2_EX,
    input  logic [XLEN-1:0]   pc_EX,
    input  logic [4:0]        rd_EX,
    input  logic              rf_wr_en_EX,
    input  logic [1:0]        rf_wr_sel_EX,
    input  logic [2:0]        dm_rd_ctrl_EX,
    input  logic [2:0]        dm_wr_ctrl_EX,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [7:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    output logic              stall_req,
    output logic [XLEN-1:0]   alu_result_MEM,
    output logic [XLEN-1:0]   mem_rdata_MEM,
    output logic [XLEN-1:0]   pc_MEM,
    output logic [4:0]        rd_MEM,
    output logic              rf_wr_en_MEM,
    output logic [1:0]        rf_wr_sel_MEM,
    output logic              misalign_MEM
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DRAIN} state_t;
    state_t state, state_nxt;

    logic            is_store, is_load, access, misaligned, issue;
    logic            signed_ld, req_c, stall_c, cap, mis_b, latch_hold;
    logic [1:0]      sz;
    logic [2:0]      off;
    logic [7:0]      wstrb;
    logic [63:0]     wdata, hold_q, raw, sh, ld_data;

    assign off      = alu_result_EX[2:0];
    assign is_store = (dm_wr_ctrl_EX != 3'd0) && (dm_wr_ctrl_EX <= 3'd4);
    assign is_load  = (dm_rd_ctrl_EX != 3'd0) && !is_store;
    assign access   = is_store || is_load;
    assign issue    = access && !misaligned;

    // sz: 0 byte, 1 half, 2 word, 3 double
    always_comb begin
        sz        = 2'd0;
        signed_ld = 1'b0;
        if (is_store) begin
            sz = 2'(dm_wr_ctrl_EX - 3'd1);
        end else begin
            case (dm_rd_ctrl_EX)
                3'd1:    begin sz = 2'd0; signed_ld = 1'b1; end
                3'd3:    begin sz = 2'd1; signed_ld = 1'b1; end
                3'd4:    sz = 2'd1;
                3'd5:    begin sz = 2'd2; signed_ld = 1'b1; end
                3'd6:    sz = 2'd2;
                3'd7:    sz = 2'd3;
                default: sz = 2'd0;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        if (access) begin
            case (sz)
                2'd1:    misaligned = off[0];
                2'd2:    misaligned = |off[1:0];
                2'd3:    misaligned = |off;
                default: misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        wstrb = 8'hFF;
        wdata = reg_data2_EX;
        case (sz)
            2'd0: begin
                wstrb = 8'h01 << off;
                wdata = {8{reg_data2_EX[7:0]}};
            end
            2'd1: begin
                wstrb = 8'h03 << off;
                wdata = {4{reg_data2_EX[15:0]}};
            end
            2'd2: begin
                wstrb = 8'h0F << off;
                wdata = {2{reg_data2_EX[31:0]}};
            end
            default: wstrb = 8'hFF;
        endcase
        if (!is_store) wstrb = 8'h00;
    end

    // HOLD replays the response latched while WB was stalled
    assign raw = (state == HOLD) ? hold_q : resp_rdata;
    assign sh  = raw >> {off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (sz)
            2'd0: ld_data = {{56{signed_ld & sh[7]}}, sh[7:0]};
            2'd1: ld_data = {{48{signed_ld & sh[15]}}, sh[15:0]};
            2'd2: ld_data = {{32{signed_ld & sh[31]}}, sh[31:0]};
            default: ld_data = sh;
        endcase
        if (!is_load) ld_data = 64'd0;
    end

    always_comb begin
        state_nxt  = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        cap        = 1'b0;
        mis_b      = 1'b0;
        latch_hold = 1'b0;
        case (state)
            IDLE: begin
                stall_c = issue;
                req_c   = issue && !flush;
                cap     = !access;
                mis_b   = access && misaligned;
                if (req_c) state_nxt = req_ready ? RESP : REQ;
            end
            REQ: begin
                stall_c = 1'b1;
                req_c   = !flush;
                if (flush)          state_nxt = IDLE;
                else if (req_ready) state_nxt = RESP;
            end
            RESP: begin
                stall_c = !resp_valid;
                cap     = resp_valid;
                if (flush) begin
                    state_nxt = resp_valid ? IDLE : DRAIN;
                end else if (resp_valid) begin
                    state_nxt  = stall ? HOLD : IDLE;
                    latch_hold = stall;
                end
            end
            HOLD: begin
                stall_c = 1'b1;
                cap     = 1'b1;
                if (flush || !stall) state_nxt = IDLE;
            end
            DRAIN: begin
                stall_c = 1'b1;
                if (resp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Comb outputs are forced low while reset is asserted
    assign req_valid = reset & req_c;
    assign stall_req = reset & stall_c;
    assign req_we    = reset & is_store;
    assign req_addr  = reset ? {alu_result_EX[ADDR_W-1:3], 3'b000} : '0;
    assign req_wdata = reset ? wdata : '0;
    assign req_wstrb = reset ? wstrb : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            hold_q         <= '0;
            alu_result_MEM <= '0;
            mem_rdata_MEM  <= '0;
            pc_MEM         <= '0;
            rd_MEM         <= '0;
            rf_wr_en_MEM   <= 1'b0;
            rf_wr_sel_MEM  <= '0;
            misalign_MEM   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_hold) hold_q <= resp_rdata;
            if (flush || (!stall && !cap)) begin
                alu_result_MEM <= '0;
                mem_rdata_MEM  <= '0;
                pc_MEM         <= '0;
                rd_MEM         <= '0;
                rf_wr_en_MEM   <= 1'b0;
                rf_wr_sel_MEM  <= '0;
                misalign_MEM   <= !flush && mis_b;
            end else if (!stall) begin
                alu_result_MEM <= alu_result_EX;
                mem_rdata_MEM  <= ld_data;
                pc_MEM         <= pc_EX;
                rd_MEM         <= rd_EX;
                rf_wr_en_MEM   <= rf_wr_en_EX;
                rf_wr_sel_MEM  <= rf_wr_sel_EX;
                misalign_MEM   <= 1'b0;
            end
        end
    end
endmodule
